// File: rtl/coproc_pkg.sv
// Shared definitions for the co-processor sequencer: state encodings,
// display source constants, default algorithm code width and the
// timeout counter width.
package coproc_pkg;

  localparam int ALG_W = 2;
  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_PROC       = 3'd2,
    ST_WAIT_FRAME = 3'd3,
    ST_SHOW       = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  localparam logic DISPLAY_ROM = 1'b0;
  localparam logic DISPLAY_RAM = 1'b1;

endpackage

// File: rtl/coproc_sequencer_sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous idle-high input,
// followed by a falling-edge detector producing a one-cycle pulse.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (all sync/edge flops go to 1)
//   din   - asynchronous input, idle high
//   fall  - one-cycle pulse on a synchronized 1->0 transition
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic sync1_q, sync2_q, prev_q;
  logic valid1_q, valid2_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      valid1_q <= 1'b1;
      valid2_q <= valid1_q;
      // Only a genuinely sampled high arms the detector, so an input held
      // low through reset cannot fire a pulse once reset is released.
      if (valid2_q && sync2_q)
        armed_q <= 1'b1;
    end
  end

  assign fall = armed_q & prev_q & ~sync2_q;

endmodule

// File: rtl/coproc_sequencer.sv
// coproc_sequencer: sequences one image-processing job per RUN press:
// start pulse, processing with timeout, wait for a frame boundary, then
// show the result. The display source only switches on frame boundaries.
//
// state      | meaning
// IDLE  (0)  | waiting for the first RUN press
// START (1)  | one-cycle PROC_START, timeout counter cleared
// PROC  (2)  | processor running, WREN high, timeout counting
// WAIT_FRAME | job done, waiting for a VGA frame boundary
// SHOW  (4)  | result on display, RUN restarts
// FAULT (5)  | processor timed out, TIMEOUT high, RUN restarts
//
// Ports:
//   CLK, RESET (async active-low)
//   RUN (async pushbutton, active-low), VGA_VS (async, active-low)
//   ALGORITHM / PROC_ALGORITHM  - algorithm code in / latched at start
//   PROC_DONE / PROC_START      - processor handshake
//   WREN, ZOOM_REQUESTED, DISPLAY_SEL, BUSY, TIMEOUT, STATE - status/control
module coproc_sequencer
  import coproc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ALG_W          = coproc_pkg::ALG_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic             VGA_VS,
  input  logic [ALG_W-1:0] ALGORITHM,
  input  logic             PROC_DONE,
  output logic             PROC_START,
  output logic [ALG_W-1:0] PROC_ALGORITHM,
  output logic             WREN,
  output logic             ZOOM_REQUESTED,
  output logic             DISPLAY_SEL,
  output logic             BUSY,
  output logic             TIMEOUT,
  output logic [2:0]       STATE
);

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ALG_W-1:0] alg_q;
  logic             timeout_q;
  logic             disp_q;
  logic             capture;
  logic             run_edge, frame_edge;

  sync_edge u_run_sync (
    .clk   (CLK),
    .rst_n (RESET),
    .din   (RUN),
    .fall  (run_edge)
  );

  sync_edge u_vs_sync (
    .clk   (CLK),
    .rst_n (RESET),
    .din   (VGA_VS),
    .fall  (frame_edge)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      alg_q     <= '0;
      timeout_q <= 1'b0;
      disp_q    <= DISPLAY_ROM;
    end else begin
      state_q <= state_d;

      if (state_q == ST_START)
        cnt_q <= '0;
      else if (state_q == ST_PROC && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CNT_W'(1);

      if (capture)
        alg_q <= ALGORITHM;

      if (state_q == ST_PROC && state_d == ST_FAULT)
        timeout_q <= 1'b1;
      else if (state_q == ST_FAULT && capture)
        timeout_q <= 1'b0;

      // Switch source only at a frame boundary to avoid tearing.
      if (frame_edge)
        disp_q <= (state_q == ST_WAIT_FRAME || state_q == ST_SHOW) ? DISPLAY_RAM
                                                                   : DISPLAY_ROM;
    end
  end

  always_comb begin
    state_d        = state_q;
    capture        = 1'b0;
    PROC_START     = 1'b0;
    WREN           = 1'b0;
    ZOOM_REQUESTED = 1'b0;
    BUSY           = 1'b0;
    case (state_q)
      ST_IDLE, ST_SHOW, ST_FAULT: begin
        if (run_edge) begin
          state_d = ST_START;
          capture = 1'b1;
        end
      end
      ST_START: begin
        PROC_START     = 1'b1;
        ZOOM_REQUESTED = 1'b1;
        BUSY           = 1'b1;
        state_d        = ST_PROC;
      end
      ST_PROC: begin
        WREN           = 1'b1;
        ZOOM_REQUESTED = 1'b1;
        BUSY           = 1'b1;
        // Completion takes priority over a coincident terminal count.
        if (PROC_DONE)
          state_d = ST_WAIT_FRAME;
        else if (cnt_q == CNT_TC)
          state_d = ST_FAULT;
      end
      ST_WAIT_FRAME: begin
        ZOOM_REQUESTED = 1'b1;
        if (frame_edge)
          state_d = ST_SHOW;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign PROC_ALGORITHM = alg_q;
  assign TIMEOUT        = timeout_q;
  assign DISPLAY_SEL    = disp_q;
  assign STATE          = state_q;

endmodule

// File: tb/tb_coproc_sequencer.sv
// Directed and randomized bench for coproc_sequencer with TIMEOUT_CYCLES=16.
// Expected behaviour comes from job-level rules: a press yields PROC_START
// three clocks later, a job runs min(done,15)+1 PROC cycles and ends in
// WAIT_FRAME (done in time) or FAULT, and the display source follows the
// job only at frame boundaries.
module tb_coproc_sequencer;

  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       RUN = 1'b1;
  logic       VGA_VS = 1'b1;
  logic [1:0] ALGORITHM = 2'd0;
  logic       PROC_DONE = 1'b0;
  logic       PROC_START;
  logic [1:0] PROC_ALGORITHM;
  logic       WREN, ZOOM_REQUESTED, DISPLAY_SEL, BUSY, TIMEOUT;
  logic [2:0] STATE;

  int checks = 0;
  int errors = 0;
  int start_pulses = 0;
  int consec_starts = 0;
  logic prev_start = 1'b0;
  logic exp_disp = 1'b0;

  coproc_sequencer #(.TIMEOUT_CYCLES(TO), .ALG_W(2)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .RUN            (RUN),
    .VGA_VS         (VGA_VS),
    .ALGORITHM      (ALGORITHM),
    .PROC_DONE      (PROC_DONE),
    .PROC_START     (PROC_START),
    .PROC_ALGORITHM (PROC_ALGORITHM),
    .WREN           (WREN),
    .ZOOM_REQUESTED (ZOOM_REQUESTED),
    .DISPLAY_SEL    (DISPLAY_SEL),
    .BUSY           (BUSY),
    .TIMEOUT        (TIMEOUT),
    .STATE          (STATE)
  );

  always #10 CLK = ~CLK;

  always @(negedge CLK) begin
    if (PROC_START) begin
      start_pulses = start_pulses + 1;
      if (prev_start) consec_starts = consec_starts + 1;
    end
    prev_start = PROC_START;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press RUN; PROC_START must appear exactly three clocks later, then PROC.
  task automatic press(input logic [1:0] alg);
    int sp;
    sp = start_pulses;
    ALGORITHM = alg;
    RUN = 1'b0;
    step();
    step();
    check("start_early", PROC_START, 0);
    step();
    check("start_pulse", PROC_START, 1);
    check("start_state", STATE, 1);
    check("start_busy", BUSY, 1);
    check("start_zoom", ZOOM_REQUESTED, 1);
    check("start_wren", WREN, 0);
    check("start_timeout", TIMEOUT, 0);
    check("start_alg", PROC_ALGORITHM, alg);
    check("start_disp", DISPLAY_SEL, exp_disp);
    RUN = 1'b1;
    ALGORITHM = 2'($urandom_range(0, 3));
    step();
    check("proc_state", STATE, 2);
    check("proc_start_low", PROC_START, 0);
    check("proc_wren", WREN, 1);
    check("start_count", start_pulses, sp + 1);
  endtask

  // Run PROC from cycle first_c; PROC_DONE in cycle done_idx (>=TO: never).
  task automatic run_proc(input int first_c, input int done_idx, input logic [1:0] alg);
    int last;
    logic fault;
    fault = (done_idx >= TO);
    last  = fault ? TO - 1 : done_idx;
    for (int c = first_c; c <= last; c++) begin
      check("proc_cyc_state", STATE, 2);
      check("proc_cyc_wren", WREN, 1);
      check("proc_cyc_busy", BUSY, 1);
      check("proc_cyc_alg", PROC_ALGORITHM, alg);
      ALGORITHM = 2'($urandom_range(0, 3));
      PROC_DONE = (c == done_idx);
      step();
      PROC_DONE = 1'b0;
    end
    check("end_state", STATE, fault ? 3'd5 : 3'd3);
    check("end_wren", WREN, 0);
    check("end_busy", BUSY, 0);
    check("end_timeout", TIMEOUT, fault);
    check("end_zoom", ZOOM_REQUESTED, !fault);
    check("end_disp", DISPLAY_SEL, exp_disp);
    check("end_alg", PROC_ALGORITHM, alg);
  endtask

  // VS low for three clocks; the frame boundary takes effect on the third.
  task automatic vs_pulse(input logic pre_disp);
    VGA_VS = 1'b0;
    step();
    step();
    check("disp_before_frame", DISPLAY_SEL, pre_disp);
    step();
    VGA_VS = 1'b1;
  endtask

  initial begin
    int sp, d, gap;
    logic [1:0] alg;

    #1;
    check("rst_state", STATE, 0);
    check("rst_wren", WREN, 0);
    check("rst_busy", BUSY, 0);
    check("rst_zoom", ZOOM_REQUESTED, 0);
    check("rst_disp", DISPLAY_SEL, 0);
    check("rst_timeout", TIMEOUT, 0);
    check("rst_alg", PROC_ALGORITHM, 0);
    check("rst_start", PROC_START, 0);
    step();
    step();
    RESET = 1'b1;
    repeat (5) step();
    check("idle_after_rst", STATE, 0);
    check("no_spurious_start", start_pulses, 0);

    // First job: done in the 10th PROC cycle, frame 50 cycles later.
    press(2'd2);
    run_proc(0, 9, 2'd2);
    repeat (49) step();
    check("wait_hold", STATE, 3);
    vs_pulse(1'b0);
    exp_disp = 1'b1;
    check("show_state", STATE, 4);
    check("show_disp", DISPLAY_SEL, 1);
    check("show_zoom", ZOOM_REQUESTED, 0);

    // Restart from SHOW: RAM kept until the next frame, then ROM.
    repeat (3) step();
    press(2'd1);
    vs_pulse(1'b1);
    exp_disp = 1'b0;
    check("restart_disp_rom", DISPLAY_SEL, 0);
    run_proc(3, 5, 2'd1);
    vs_pulse(1'b0);
    exp_disp = 1'b1;
    check("show2_state", STATE, 4);
    check("show2_disp", DISPLAY_SEL, 1);

    // Press during PROC is ignored; then time out with no PROC_DONE.
    repeat (2) step();
    press(2'd1);
    sp = start_pulses;
    ALGORITHM = 2'd3;
    RUN = 1'b0;
    repeat (3) step();
    RUN = 1'b1;
    repeat (2) step();
    check("ignored_press_state", STATE, 2);
    check("ignored_press_alg", PROC_ALGORITHM, 1);
    check("ignored_press_count", start_pulses, sp);
    run_proc(5, 99, 2'd1);

    // Restart from FAULT clears TIMEOUT; tie of DONE and terminal count.
    repeat (4) step();
    check("fault_sticky", TIMEOUT, 1);
    press(2'd2);
    run_proc(0, TO - 1, 2'd2);
    vs_pulse(1'b1);
    check("show3_state", STATE, 4);

    // Reset in PROC with RUN held low.
    sp = start_pulses;
    ALGORITHM = 2'd2;
    RUN = 1'b0;
    repeat (4) step();
    check("pre_reset_state", STATE, 2);
    #3 RESET = 1'b0;
    #1;
    exp_disp = 1'b0;
    check("async_rst_wren", WREN, 0);
    check("async_rst_busy", BUSY, 0);
    check("async_rst_state", STATE, 0);
    check("async_rst_alg", PROC_ALGORITHM, 0);
    check("async_rst_disp", DISPLAY_SEL, 0);
    step();
    step();
    RESET = 1'b1;
    repeat (10) step();
    check("held_run_state", STATE, 0);
    check("held_run_count", start_pulses, sp + 1);
    RUN = 1'b1;
    repeat (5) step();
    check("released_run_count", start_pulses, sp + 1);
    press(2'd3);
    run_proc(0, 2, 2'd3);
    vs_pulse(1'b0);
    exp_disp = 1'b1;
    check("show4_state", STATE, 4);

    // Randomized jobs checked against the job-level rules.
    for (int j = 0; j < 10; j++) begin
      alg = 2'($urandom_range(0, 3));
      d   = int'($urandom_range(0, 19));
      repeat ($urandom_range(1, 4)) step();
      press(alg);
      run_proc(0, d, alg);
      if (d < TO) begin
        gap = int'($urandom_range(0, 6));
        repeat (gap) step();
        check("rnd_wait_state", STATE, 3);
        vs_pulse(exp_disp);
        exp_disp = 1'b1;
        check("rnd_show_state", STATE, 4);
        check("rnd_show_disp", DISPLAY_SEL, 1);
      end else begin
        check("rnd_fault_disp", DISPLAY_SEL, exp_disp);
      end
    end

    check("no_double_start", consec_starts, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
